seq_detector_test_sequencer: RTL and testbench
==============================================

# seq_detector_test_sequencer

Sequencer that drives a stored bit pattern, one bit per clock, into two copies of the serial sequence detector. It does this through a shared `j` input and a shared detector reset. It compares the two `w` outputs every cycle and counts both detections and mismatches. It sits between a host/bench that supplies a pattern with a start pulse and the two detector instances (pre- and post-synthesis netlists), replacing hand-written stimulus timing with a repeatable, self-checking run.

## Interface
- `LEN`, 16: number of pattern bits streamed per run (≥2).
- `LAT`, 1: detector output latency in clocks after the last `j` bit; sets the drain length (≥0).
- `CW`, `$clog2(LEN+LAT+1)`: counter/index width (derived, not overridden).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request a run; sampled only in IDLE.
- `pattern` in LEN: bits to stream, MSB first; captured in the start cycle.
- `busy` out 1: high from LOAD through DONE inclusive.
- `done` out 1: one-cycle pulse in DONE.
- `det_rst_n` out 1: active-low reset to both detectors.
- `j` out 1: serial bit to both detectors.
- `w_a` in 1: output of detector A (reference copy).
- `w_b` in 1: output of detector B (copy under check).
- `detect_cnt` out CW: cycles with `w_a`=1 inside the compare window.
- `mismatch_cnt` out CW: cycles with `w_a`≠`w_b` inside the compare window.
- `first_mis_idx` out CW: compare-window index of the first mismatch; all-ones if there is none.

## Operation
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE → LOAD when `start`=1. `pattern` is latched into the shift register on that edge.
- LOAD lasts 1 cycle:
  - `det_rst_n`=0.
  - `detect_cnt`, `mismatch_cnt` cleared to 0.
  - `first_mis_idx` set to all-ones.
  - Bit counter set to 0.
- STREAM lasts exactly LEN cycles:
  - `j` equals the shift-register MSB; the register shifts left each cycle.
  - Stream cycle n (0-based) drives `pattern[LEN-1-n]`.
- DRAIN lasts exactly LAT cycles with `j`=0. If LAT=0, STREAM goes directly to DONE.
- DONE lasts 1 cycle with `done`=1, then returns to IDLE.
- Compare window covers every STREAM and DRAIN cycle, indices 0..LEN+LAT-1. In each window cycle:
  - `detect_cnt` += `w_a`.
  - `mismatch_cnt` += (`w_a`^`w_b`).
  - On the first mismatch, `first_mis_idx` ← current index.
- Counters cannot overflow, because their maximum is LEN+LAT < 2^CW. No saturation logic.
- Results hold from DONE until the next LOAD.
- `start` outside IDLE is ignored, not queued.
- Outside LOAD, `det_rst_n` = `rst`, so the detectors are also held in reset during a global reset.
- `j`=0 in every state except STREAM.

## Timing
- Reset values while `rst`=0:
  - state IDLE.
  - `busy`=0, `done`=0, `j`=0, `det_rst_n`=0.
  - `detect_cnt`=0, `mismatch_cnt`=0.
  - `first_mis_idx`=all-ones.
- Reset mid-run aborts immediately to these values. No `done` is produced.
- Latency: `start` high at edge k puts LOAD in cycle k+1. The first `j` bit is in cycle k+2. `done` is in cycle k+2+LEN+LAT.
- Minimum start-to-start spacing is LEN+LAT+3 cycles. A `start` held high in DONE is ignored; the same `start` held high in the following IDLE cycle launches a new run.
- `w_a`/`w_b` are sampled on the rising edge closing each window cycle. Counter updates are visible the next cycle, and final values are stable in DONE.
- `busy`, `done`, `j` and state are registered-state decodes with no combinational path from `start`. `det_rst_n` is the only output that is combinational from `rst`.

## Structure
- Package `seq_tester_pkg`: state enum (IDLE, LOAD, STREAM, DRAIN, DONE) and default constants `LEN_DEF`=16, `LAT_DEF`=1.
- Sub-module `pattern_shifter`:
  - parallel load, left shift on enable, MSB out.
  - parameter LEN; same `clk`/`rst`.
- The top holds the FSM, bit/drain counter, compare logic and result registers.

## Test plan
- `w_b` tied to `w_a`, pattern 16'hC940: `done` in cycle k+19. `mismatch_cnt`=0, `first_mis_idx`=31. The `j` sequence equals 1,1,0,0,1,0,0,1,0,1,0,0,0,0,0,0.
- Force `w_b`=~`w_a` only in window index 5: `mismatch_cnt`=1, `first_mis_idx`=5. Force it at indices 5 and 9: `mismatch_cnt`=2, `first_mis_idx`=5.
- `w_a`=`w_b`=1 constant: `detect_cnt`=17, `mismatch_cnt`=0.
- Pulse `start` during STREAM and during DONE: no restart. `done` pulses exactly once and results are unchanged. A `start` in the next IDLE cycle begins LOAD one cycle later.
- Assert `rst`=0 at stream index 7: all outputs go immediately to their reset values with `j`=0 and `det_rst_n`=0. After release: IDLE, no `done`.
- LAT=0 build: `done` in cycle k+18, compare window 16 cycles, all-ones sentinel = 31.

Source files
------------

// File: rtl/seq_tester_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_tester_pkg
//  Purpose  : Shared state encoding and default build constants for the
//             serial sequence-detector test sequencer.
//  Contents : LEN_DEF / LAT_DEF defaults, state_t enumeration.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_tester_pkg;

    localparam int LEN_DEF = 16;
    localparam int LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_detector_test_sequencer_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_shifter
//  Purpose  : Parallel-load, shift-left register presenting its MSB as the
//             serial stream bit.
//  Ports    : clk, rst (async active-low), i_load / i_din (parallel load),
//             i_shift (shift left by one, zero fill), o_msb (current bit).
//  Revision : 1.0 - initial release
// ============================================================================
module pattern_shifter
    import seq_tester_pkg::*;
#(
    parameter int LEN = LEN_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic           i_shift,
    input  logic [LEN-1:0] i_din,
    output logic           o_msb
);

    logic [LEN-1:0] r_sr;

    // Load wins over shift; the two are never requested together by the top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_din;
        end else if (i_shift) begin
            r_sr <= {r_sr[LEN-2:0], 1'b0};
        end
    end

    assign o_msb = r_sr[LEN-1];

endmodule
`default_nettype wire

// File: rtl/seq_detector_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_test_sequencer
//  Purpose  : Streams a captured LEN-bit pattern (MSB first) into two copies
//             of a serial detector through a shared j / det_rst_n, then
//             compares their w outputs over STREAM+DRAIN and reports counts.
//  Ports    : clk, rst (async active-low), start, pattern  -> run control
//             busy, done                                    -> run status
//             det_rst_n, j                                  -> detector drive
//             w_a, w_b                                      -> detector outputs
//             detect_cnt, mismatch_cnt, first_mis_idx       -> results
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector_test_sequencer
    import seq_tester_pkg::*;
#(
    parameter  int LEN = LEN_DEF,
    parameter  int LAT = LAT_DEF,
    localparam int CW  = $clog2(LEN + LAT + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LEN-1:0] pattern,
    output logic           busy,
    output logic           done,
    output logic           det_rst_n,
    output logic           j,
    input  logic           w_a,
    input  logic           w_b,
    output logic [CW-1:0]  detect_cnt,
    output logic [CW-1:0]  mismatch_cnt,
    output logic [CW-1:0]  first_mis_idx
);

    localparam logic [CW-1:0] c_LAST_STREAM = CW'(LEN - 1);
    localparam logic [CW-1:0] c_LAST_WIN    = CW'(LEN + LAT - 1);
    localparam logic [CW-1:0] c_NO_MIS      = '1;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_idx;
    logic          w_msb;
    logic          w_load;
    logic          w_window;

    // Pattern is captured on the same edge that moves IDLE -> LOAD.
    assign w_load   = (r_state == IDLE) && start;
    assign w_window = (r_state == STREAM) || (r_state == DRAIN);

    pattern_shifter #(
        .LEN (LEN)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (r_state == STREAM),
        .i_din   (pattern),
        .o_msb   (w_msb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = STREAM;
            STREAM:  if (r_idx == c_LAST_STREAM) w_next = (LAT == 0) ? DONE : DRAIN;
            DRAIN:   if (r_idx == c_LAST_WIN) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Window index: runs 0..LEN-1 through STREAM and continues through DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (r_state == LOAD) begin
            r_idx <= '0;
        end else if (w_window) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Results. LEN+LAT < 2**CW, so the counters cannot wrap within a run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            detect_cnt    <= '0;
            mismatch_cnt  <= '0;
            first_mis_idx <= c_NO_MIS;
        end else if (r_state == LOAD) begin
            detect_cnt    <= '0;
            mismatch_cnt  <= '0;
            first_mis_idx <= c_NO_MIS;
        end else if (w_window) begin
            detect_cnt <= detect_cnt + CW'(w_a);
            if (w_a ^ w_b) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
                // A zero mismatch count marks this as the first one of the run.
                if (mismatch_cnt == '0) begin
                    first_mis_idx <= r_idx;
                end
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign j         = (r_state == STREAM) && w_msb;
    // Detectors follow the global reset and are additionally pulsed in LOAD.
    assign det_rst_n = (r_state == LOAD) ? 1'b0 : rst;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_test_sequencer
//  Purpose  : Self-checking bench for seq_detector_test_sequencer. Drives the
//             default build (LAT=1) and a LAT=0 build side by side and checks
//             timing, j stream and results against a window-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_test_sequencer;

    localparam int LEN = 16;
    localparam int CW  = 5;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          start   = 1'b0;
    logic          start0  = 1'b0;
    logic [LEN-1:0] pattern = '0;
    logic          w_a     = 1'b0;
    logic          w_b     = 1'b0;

    logic          busy, done, det_rst_n, j;
    logic [CW-1:0] detect_cnt, mismatch_cnt, first_mis_idx;
    logic          busy0, done0, det_rst_n0, j0;
    logic [CW-1:0] detect_cnt0, mismatch_cnt0, first_mis_idx0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_detector_test_sequencer #(.LEN(16), .LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .busy(busy), .done(done), .det_rst_n(det_rst_n), .j(j),
        .w_a(w_a), .w_b(w_b), .detect_cnt(detect_cnt),
        .mismatch_cnt(mismatch_cnt), .first_mis_idx(first_mis_idx)
    );

    seq_detector_test_sequencer #(.LEN(16), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pattern(pattern),
        .busy(busy0), .done(done0), .det_rst_n(det_rst_n0), .j(j0),
        .w_a(w_a), .w_b(w_b), .detect_cnt(detect_cnt0),
        .mismatch_cnt(mismatch_cnt0), .first_mis_idx(first_mis_idx0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model (per-window bit vectors) -------------
    function automatic int popc(input logic [31:0] v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int first_set(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 31;
    endfunction

    task automatic check_results(input string tag, input logic [31:0] wa, input logic [31:0] wb, input bit lat0);
        logic [31:0] m;
        m = lat0 ? 32'h0000_FFFF : 32'h0001_FFFF;
        if (lat0) begin
            check({tag, "_det0"},   detect_cnt0,    popc(wa & m));
            check({tag, "_mis0"},   mismatch_cnt0,  popc((wa ^ wb) & m));
            check({tag, "_first0"}, first_mis_idx0, first_set((wa ^ wb) & m));
        end else begin
            check({tag, "_det"},   detect_cnt,    popc(wa & m));
            check({tag, "_mis"},   mismatch_cnt,  popc((wa ^ wb) & m));
            check({tag, "_first"}, first_mis_idx, first_set((wa ^ wb) & m));
        end
    endtask

    // mode 0: plain run; 1: start pulses in STREAM and DONE (ignored);
    // 2: start held from DONE into IDLE (new run launches).
    task automatic do_run(input logic [15:0] pat, input logic [31:0] wa, input logic [31:0] wb, input int mode);
        int waited;
        @(negedge clk);
        pattern = pat;
        start   = 1'b1;
        start0  = 1'b1;
        @(negedge clk);                           // LOAD cycle (k+1)
        start   = 1'b0;
        start0  = 1'b0;
        check("load_busy", busy, 1);
        check("load_detrst", det_rst_n, 0);
        check("load_detrst0", det_rst_n0, 0);
        check("load_j", j, 0);
        for (int n = 0; n <= LEN; n++) begin
            @(negedge clk);                       // window cycle n (k+2+n)
            if (n < LEN) begin
                check("stream_j", j, pat[LEN-1-n]);
                check("stream_j0", j0, pat[LEN-1-n]);
                check("done0_early", done0, 0);
            end else begin
                check("drain_j", j, 0);
                check("done0_k18", done0, 1);
                check_results("lat0", wa, wb, 1'b1);
            end
            check("win_done", done, 0);
            check("win_busy", busy, 1);
            check("win_detrst", det_rst_n, 1);
            w_a   = wa[n];
            w_b   = wb[n];
            start = (mode == 1 && n == 3);
        end
        @(negedge clk);                           // DONE cycle (k+19)
        w_a = 1'b0;
        w_b = 1'b0;
        check("done_k19", done, 1);
        check("done_busy", busy, 1);
        check("done_j", j, 0);
        check("done0_idle", busy0, 0);
        check_results("run", wa, wb, 1'b0);
        if (mode != 0) start = 1'b1;
        @(negedge clk);                           // IDLE
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check_results("hold", wa, wb, 1'b0);
        if (mode == 1) begin
            start = 1'b0;
            @(negedge clk);
            check("norestart_busy", busy, 0);
            check("norestart_done", done, 0);
        end else if (mode == 2) begin
            @(negedge clk);                       // LOAD of the relaunched run
            start = 1'b0;
            check("relaunch_busy", busy, 1);
            check("relaunch_detrst", det_rst_n, 0);
            waited = 0;
            while (!done && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            check("relaunch_done", done, 1);
            check("relaunch_det", detect_cnt, 0);
            check("relaunch_mis", mismatch_cnt, 0);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_done"},   done, 0);
        check({tag, "_j"},      j, 0);
        check({tag, "_detrst"}, det_rst_n, 0);
        check({tag, "_det"},    detect_cnt, 0);
        check({tag, "_mis"},    mismatch_cnt, 0);
        check({tag, "_first"},  first_mis_idx, 31);
        check({tag, "_busy0"},  busy0, 0);
    endtask

    initial begin
        logic [31:0] wa, wb;
        #12;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_detrst", det_rst_n, 1);

        // Directed cases.
        wa = $urandom;
        do_run(16'hC940, wa, wa, 0);
        do_run(16'hC940, wa, wa ^ 32'h20, 0);
        do_run(16'hA5A5, wa, wa ^ 32'h220, 0);
        do_run(16'h1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_run(16'h8001, $urandom, $urandom, 1);
        do_run(16'h7FFE, $urandom, $urandom, 2);
        // Mismatch only in the drain cycle: invisible to the LAT=0 build.
        do_run(16'h0F0F, 32'h0, 32'h10000, 0);

        // Randomized runs with sparse disagreements.
        for (int t = 0; t < 8; t++) begin
            wa = $urandom;
            wb = wa ^ ((t % 3 == 0) ? 32'h0 : ($urandom & $urandom & $urandom));
            do_run(16'($urandom), wa, wb, 0);
        end

        // Reset mid-stream at window index 7.
        @(negedge clk);
        pattern = 16'hFFFF;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        w_a     = 1'b1;
        w_b     = 1'b0;
        for (int n = 0; n <= 7; n++) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b1;
        w_a = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("postrst_busy", busy, 0);
            check("postrst_done", done, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
